vga_line_fetch_ctrl: RTL and testbench



---
 rtl/vga_line_fetch_ctrl.sv | 135 +++++++++++++
 tb/tb_vga_line_fetch_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_fetch_ctrl.sv
// Ping-pong line buffer that fetches the next display line from frame memory while the current one is shown.
// Optional colour-bar test pattern (iPattern_Sel input) when LF_PATTERN_EN is defined.
module vga_line_fetch_ctrl #(
  parameter int unsigned H_ACT  = 640,
  parameter int unsigned V_ACT  = 480,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned PIX_W  = 10
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic                 iFrame_Start,
  input  logic                 iLine_Start,
  input  logic [ADDR_W-1:0]    iBase_Addr,
  output logic                 oMem_Req,
  output logic [ADDR_W-1:0]    oMem_Addr,
  input  logic                 iMem_Ack,
  input  logic [3*PIX_W-1:0]   iMem_Data,
  input  logic [11:0]          iRd_X,
`ifdef LF_PATTERN_EN
  input  logic                 iPattern_Sel,
`endif
  output logic [PIX_W-1:0]     oPixel_R,
  output logic [PIX_W-1:0]     oPixel_G,
  output logic [PIX_W-1:0]     oPixel_B,
  output logic                 oFetch_Busy,
  output logic                 oUnderrun
);

  localparam int unsigned XW    = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int unsigned LW    = (V_ACT > 1) ? $clog2(V_ACT) : 1;
  localparam int unsigned DEPTH = 2 * H_ACT;
  localparam int unsigned BW    = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t              state;
  logic                wr_bank;
  logic                disp_bank;
  logic                frame_valid;
  logic [LW-1:0]       fetch_line;
  logic [XW-1:0]       x_cnt;
  logic [ADDR_W-1:0]   line_base;
  logic                pattern_on;
  logic                step;
  logic                wr_en;
  logic [BW-1:0]       wr_idx;
  logic [BW-1:0]       rd_idx;
  logic                rd_in_range;
  logic [3*PIX_W-1:0]  pix_next;
  logic [3*PIX_W-1:0]  line_buf [DEPTH];

`ifdef LF_PATTERN_EN
  localparam int unsigned BAR_W = (H_ACT >= 8) ? H_ACT / 8 : 1;
  logic [2:0] bar;
  assign pattern_on = iPattern_Sel;
  assign bar        = 3'({20'd0, iRd_X} / BAR_W);
`else
  assign pattern_on = 1'b0;
`endif

  assign step        = (state == REQ) && (pattern_on || iMem_Ack);
  assign wr_en       = (state == REQ) && !pattern_on && iMem_Ack;
  assign oMem_Req    = (state == REQ) && !pattern_on;
  assign oMem_Addr   = line_base + ADDR_W'(x_cnt);
  assign oFetch_Busy = (state == REQ);

  assign wr_idx      = (wr_bank ? BW'(H_ACT) : '0) + BW'(x_cnt);
  assign rd_idx      = (disp_bank ? BW'(H_ACT) : '0) + BW'(iRd_X);
  assign rd_in_range = ({20'd0, iRd_X} < H_ACT);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state       <= IDLE;
      wr_bank     <= 1'b0;
      disp_bank   <= 1'b1;
      frame_valid <= 1'b0;
      fetch_line  <= '0;
      x_cnt       <= '0;
      line_base   <= '0;
      oUnderrun   <= 1'b0;
    end else if (iFrame_Start) begin
      state       <= REQ;
      wr_bank     <= 1'b0;
      frame_valid <= 1'b1;
      fetch_line  <= '0;
      x_cnt       <= '0;
      line_base   <= iBase_Addr;
      oUnderrun   <= 1'b0;
    end else if (iLine_Start) begin
      if (state == REQ) oUnderrun <= 1'b1;
      disp_bank <= wr_bank;
      wr_bank   <= ~wr_bank;
      x_cnt     <= '0;
      // Line starts before any frame start only swap banks; fetching waits for a frame base.
      if (frame_valid && (fetch_line < LW'(V_ACT - 1))) begin
        fetch_line <= fetch_line + LW'(1);
        line_base  <= line_base + ADDR_W'(H_ACT);
        state      <= REQ;
      end else begin
        state <= IDLE;
      end
    end else if (step) begin
      if (x_cnt == XW'(H_ACT - 1)) state <= DONE;
      else x_cnt <= x_cnt + XW'(1);
    end
  end

  // An ack coinciding with an aborting line start still lands, since the write is not gated by the pulses.
  always_ff @(posedge iCLK) begin
    if (wr_en) line_buf[wr_idx] <= iMem_Data;
  end

  always_comb begin
    pix_next = '0;
    if (rd_in_range) begin
`ifdef LF_PATTERN_EN
      if (pattern_on) pix_next = {{PIX_W{~bar[1]}}, {PIX_W{~bar[2]}}, {PIX_W{~bar[0]}}};
      else            pix_next = line_buf[rd_idx];
`else
      pix_next = line_buf[rd_idx];
`endif
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oPixel_R <= '0;
      oPixel_G <= '0;
      oPixel_B <= '0;
    end else begin
      {oPixel_R, oPixel_G, oPixel_B} <= pix_next;
    end
  end

endmodule

// File: tb/tb_vga_line_fetch_ctrl.sv
// Bench for vga_line_fetch_ctrl on a small 8x4 geometry with a randomised frame-memory responder.
module tb_vga_line_fetch_ctrl;
  localparam int unsigned H = 8, V = 4, AW = 9, PW = 10;

  logic clk = 1'b0;
  logic rst_n, frame_start, line_start, mem_req, mem_ack, busy, underrun;
  logic [AW-1:0] base_addr, mem_addr;
  logic [3*PW-1:0] mem_data;
  logic [11:0] rd_x;
  logic [PW-1:0] pix_r, pix_g, pix_b;
`ifdef LF_PATTERN_EN
  logic pattern_sel;
`endif

  int unsigned vectors = 0, errors = 0;
  logic [AW-1:0] log_q[$];
  int unsigned ack_mode = 0, ack_limit = 0, stall_cnt = 0;

  // Reference model of what each bank should hold, kept in terms of line base addresses.
  logic [AW-1:0] bank_base[2];
  int unsigned   fill[2];
  bit            tb_wr, tb_disp, tb_fetching, tb_framed, tb_underrun, pat_mode;
  int unsigned   tb_line;
  logic [AW-1:0] tb_base;

  always #5 clk = ~clk;

  vga_line_fetch_ctrl #(.H_ACT(H), .V_ACT(V), .ADDR_W(AW), .PIX_W(PW)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iFrame_Start(frame_start), .iLine_Start(line_start),
    .iBase_Addr(base_addr), .oMem_Req(mem_req), .oMem_Addr(mem_addr), .iMem_Ack(mem_ack),
    .iMem_Data(mem_data), .iRd_X(rd_x),
`ifdef LF_PATTERN_EN
    .iPattern_Sel(pattern_sel),
`endif
    .oPixel_R(pix_r), .oPixel_G(pix_g), .oPixel_B(pix_b),
    .oFetch_Busy(busy), .oUnderrun(underrun));

  function automatic logic [3*PW-1:0] word_of(input logic [AW-1:0] a);
    return {a, ~a, a, 3'b101};
  endfunction

  always @(negedge clk) begin
    mem_data = word_of(mem_addr);
    mem_ack  = 1'b0;
    if (mem_req === 1'b1) begin
      case (ack_mode)
        0: mem_ack = 1'b1;
        1: begin
          mem_ack   = (stall_cnt == 2);
          stall_cnt = (stall_cnt == 2) ? 0 : stall_cnt + 1;
        end
        default: mem_ack = (log_q.size() < ack_limit);
      endcase
    end
  end

  always @(posedge clk)
    if (rst_n === 1'b1 && mem_req === 1'b1 && mem_ack === 1'b1) log_q.push_back(mem_addr);

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    tb_wr = 0; tb_disp = 1; tb_fetching = 0; tb_framed = 0; tb_underrun = 0;
    tb_line = 0; tb_base = '0; fill[0] = 0; fill[1] = 0;
  endtask

  task automatic pulse(input bit fs, input bit ls, input logic [AW-1:0] b);
    int unsigned sz0 = log_q.size();
    frame_start = fs; line_start = ls; base_addr = b;
    @(posedge clk); #1;
    frame_start = 0; line_start = 0;
    if (fs) begin
      fill[0] = 0; fill[1] = 0; tb_wr = 0; tb_base = b; tb_line = 0;
      tb_fetching = 1; tb_framed = 1; tb_underrun = 0;
    end else if (ls) begin
      if (tb_fetching && sz0 < H) tb_underrun = 1;
      if (tb_fetching) begin
        fill[tb_wr] = (log_q.size() > H) ? H : log_q.size();
        bank_base[tb_wr] = tb_base;
      end
      tb_disp = tb_wr; tb_wr = ~tb_wr;
      if (tb_framed && tb_line < V - 1) begin
        tb_line++; tb_base = AW'(tb_base + H); tb_fetching = 1; fill[tb_wr] = 0;
      end else tb_fetching = 0;
    end
    log_q.delete();
  endtask

  task automatic run_fetch(input string name, input int unsigned max_cycles, input bit exact);
    int unsigned cyc = 0;
    logic [AW-1:0] b = tb_base;
    while (log_q.size() < H && cyc < max_cycles) begin
      vectors++;
      if (mem_req !== 1'b1 || busy !== 1'b1 || mem_addr !== AW'(b + log_q.size())) begin
        errors++;
        $display("FAIL %s_req: req=%b busy=%b addr=%h, expected req=1 busy=1 addr=%h",
                 name, mem_req, busy, mem_addr, AW'(b + log_q.size()));
      end
      step(); cyc++;
    end
    vectors++;
    if (log_q.size() != H) begin
      errors++; $display("FAIL %s_timeout: %0d words after %0d cycles, expected %0d", name, log_q.size(), cyc, H);
    end
    vectors++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL %s_done: busy=%b req=%b, expected 0 0", name, busy, mem_req);
    end
    for (int i = 0; i < log_q.size(); i++) begin
      vectors++;
      if (log_q[i] !== AW'(b + i)) begin
        errors++; $display("FAIL %s_addr%0d: acked %h, expected %h", name, i, log_q[i], AW'(b + i));
      end
    end
    if (exact) begin
      vectors++;
      if (cyc != H) begin
        errors++; $display("FAIL %s_rate: %0d cycles, expected %0d", name, cyc, H);
      end
    end
  endtask

  task automatic check_pixels(input string name, input int unsigned n);
    int unsigned x;
    logic [3*PW-1:0] exp;
    bit chk;
    for (int k = 0; k < n + 1; k++) begin
      x = (k == n) ? 12'hFFF : $urandom_range(0, H + 2);
      rd_x = 12'(x);
      step();
      chk = 1; exp = '0;
      if (x < H) begin
        if (x < fill[tb_disp]) exp = word_of(AW'(bank_base[tb_disp] + x));
        else chk = 0;
      end
      if (chk) begin
        vectors++;
        if ({pix_r, pix_g, pix_b} !== exp) begin
          errors++; $display("FAIL %s_pix_x%0d: got %h, expected %h", name, x, {pix_r, pix_g, pix_b}, exp);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    step();
    vectors++;
    if ({mem_req, mem_addr, busy, underrun, pix_r, pix_g, pix_b} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h, expected 0", {mem_req, mem_addr, busy, underrun, pix_r, pix_g, pix_b});
    end
    step(); step();
    rst_n = 1;
    model_reset();
    pulse(0, 1, '0);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (mem_req !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL reset_no_req: req=%b busy=%b, expected 0 0", mem_req, busy);
      end
      step();
    end
  endtask

  task automatic test_basic_fetch();
    logic [AW-1:0] old_base;
    ack_mode = 0;
    pulse(1, 0, 9'h100);
    run_fetch("line0", 40, 1);
    pulse(0, 1, '0);
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 9'h108) begin
      errors++; $display("FAIL line1_start: req=%b addr=%h, expected 1 108", mem_req, mem_addr);
    end
    run_fetch("line1", 40, 1);
    check_pixels("basic", 10);
    // Bank swap visible only on the read issued after the line-start edge.
    rd_x = 12'd3; old_base = bank_base[tb_disp];
    ack_mode = 1; stall_cnt = 0;
    pulse(0, 1, '0);
    vectors++;
    if ({pix_r, pix_g, pix_b} !== word_of(AW'(old_base + 3))) begin
      errors++; $display("FAIL swap_old: got %h, expected %h", {pix_r, pix_g, pix_b}, word_of(AW'(old_base + 3)));
    end
    step();
    vectors++;
    if ({pix_r, pix_g, pix_b} !== word_of(AW'(bank_base[tb_disp] + 3))) begin
      errors++; $display("FAIL swap_new: got %h, expected %h", {pix_r, pix_g, pix_b}, word_of(AW'(bank_base[tb_disp] + 3)));
    end
  endtask

  task automatic test_ack_stall();
    run_fetch("stall", 60, 0);
    ack_mode = 0;
    pulse(0, 1, '0);
    run_fetch("line3", 40, 1);
    check_pixels("stall", 10);
  endtask

  task automatic test_end_of_frame();
    for (int p = 0; p < 2; p++) begin
      pulse(0, 1, '0);
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || underrun !== 1'b0) begin
          errors++; $display("FAIL eof_idle: req=%b busy=%b underrun=%b, expected 0 0 0", mem_req, busy, underrun);
        end
        step();
      end
    end
    check_pixels("eof", 6);
  endtask

  task automatic test_underrun();
    logic [AW-1:0] b;
    int unsigned cyc;
    b = AW'($urandom_range(0, 511));
    ack_mode = 2; ack_limit = 5;
    pulse(1, 0, b);
    cyc = 0;
    while (log_q.size() < 5 && cyc < 40) begin step(); cyc++; end
    step(); step(); step();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== AW'(b + 5) || underrun !== 1'b0) begin
      errors++; $display("FAIL ur_hold: req=%b addr=%h underrun=%b, expected 1 %h 0", mem_req, mem_addr, underrun, AW'(b + 5));
    end
    pulse(0, 1, '0);
    vectors++;
    if (underrun !== tb_underrun || mem_req !== 1'b1 || mem_addr !== tb_base) begin
      errors++; $display("FAIL ur_set: underrun=%b req=%b addr=%h, expected %b 1 %h", underrun, mem_req, mem_addr, tb_underrun, tb_base);
    end
    ack_mode = 0;
    run_fetch("ur_next", 40, 1);
    check_pixels("ur", 12);
    b = AW'($urandom_range(0, 511));
    ack_mode = 2; ack_limit = 2;
    pulse(1, 1, b);
    vectors++;
    if (underrun !== 1'b0 || mem_req !== 1'b1 || mem_addr !== b) begin
      errors++; $display("FAIL coincide: underrun=%b req=%b addr=%h, expected 0 1 %h", underrun, mem_req, mem_addr, b);
    end
    for (int i = 0; i < 6; i++) step();
    pulse(0, 1, '0);
    vectors++;
    if (underrun !== 1'b1 || mem_addr !== AW'(b + H)) begin
      errors++; $display("FAIL ur_again: underrun=%b addr=%h, expected 1 %h", underrun, mem_addr, AW'(b + H));
    end
    b = AW'($urandom_range(0, 511));
    pulse(1, 0, b);
    vectors++;
    if (underrun !== 1'b0 || mem_req !== 1'b1 || mem_addr !== b) begin
      errors++; $display("FAIL ur_clear: underrun=%b req=%b addr=%h, expected 0 1 %h", underrun, mem_req, mem_addr, b);
    end
    ack_mode = 0;
    run_fetch("ur_restart", 40, 0);
  endtask

  task automatic test_wrap();
    ack_mode = 0;
    pulse(1, 0, 9'h1FC);
    run_fetch("wrap", 40, 1);
    pulse(0, 1, '0);
    check_pixels("wrap", 12);
    rd_x = 12'd8;
    step();
    vectors++;
    if ({pix_r, pix_g, pix_b} !== '0) begin
      errors++; $display("FAIL range_x8: got %h, expected 0", {pix_r, pix_g, pix_b});
    end
  endtask

  task automatic test_async_reset();
    logic [AW-1:0] b;
    int unsigned cyc;
    b = AW'($urandom_range(0, 511));
    ack_mode = 2; ack_limit = 3;
    pulse(1, 0, b);
    cyc = 0;
    while (log_q.size() < 3 && cyc < 40) begin step(); cyc++; end
    step();
    pulse(0, 1, '0);
    for (int i = 0; i < 6; i++) step();
    rd_x = 12'd1;
    step();
    vectors++;
    if ({pix_r, pix_g, pix_b} !== word_of(AW'(b + 1)) || underrun !== 1'b1 || mem_req !== 1'b1) begin
      errors++; $display("FAIL pre_reset: pix=%h underrun=%b req=%b, expected %h 1 1", {pix_r, pix_g, pix_b}, underrun, mem_req, word_of(AW'(b + 1)));
    end
    #2 rst_n = 0;
    #1;
    vectors++;
    if ({mem_req, mem_addr, busy, underrun, pix_r, pix_g, pix_b} !== '0) begin
      errors++; $display("FAIL async_reset: got %h, expected 0", {mem_req, mem_addr, busy, underrun, pix_r, pix_g, pix_b});
    end
    step();
    rst_n = 1;
    model_reset();
    ack_mode = 0;
    pulse(0, 1, '0);
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (mem_req !== 1'b0) begin
        errors++; $display("FAIL post_reset_req: req=%b, expected 0", mem_req);
      end
      step();
    end
  endtask

`ifdef LF_PATTERN_EN
  task automatic test_pattern();
    logic [2:0] colours [8];
    logic [2:0] c;
    logic [3*PW-1:0] exp;
    colours = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
    pattern_sel = 1; pat_mode = 1;
    pulse(1, 0, '0);
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (mem_req !== 1'b0 || busy !== (i < H)) begin
        errors++; $display("FAIL pat_fsm%0d: req=%b busy=%b, expected 0 %b", i, mem_req, busy, (i < H));
      end
      step();
    end
    for (int x = 0; x <= H; x++) begin
      rd_x = 12'(x);
      step();
      exp = '0;
      if (x < H) begin
        c = colours[x / (H / 8)];
        exp = {{PW{c[2]}}, {PW{c[1]}}, {PW{c[0]}}};
      end
      vectors++;
      if ({pix_r, pix_g, pix_b} !== exp) begin
        errors++; $display("FAIL pat_pix_x%0d: got %h, expected %h", x, {pix_r, pix_g, pix_b}, exp);
      end
    end
    pattern_sel = 0; pat_mode = 0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 0; frame_start = 0; line_start = 0; base_addr = '0; rd_x = '0;
    mem_ack = 0; mem_data = '0; pat_mode = 0;
    bank_base[0] = '0; bank_base[1] = '0;
`ifdef LF_PATTERN_EN
    pattern_sel = 0;
`endif
    model_reset();
    test_reset();
    test_basic_fetch();
    test_ack_stall();
    test_end_of_frame();
    test_underrun();
    test_wrap();
    test_async_reset();
`ifdef LF_PATTERN_EN
    test_pattern();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
